// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared types and default geometry for the framebuffer arbiter
package fb_pkg;

  localparam int FB_ADDR_WIDTH = 11;
  localparam int FB_DATA_WIDTH = 24;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_SCAN = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    CLR_IDLE = 2'd0,
    CLR_FILL = 2'd1,
    CLR_DONE = 2'd2
  } clr_state_e;

endpackage

// File: rtl/framebuffer_arbiter_if.sv
// rtl/framebuffer_arbiter_if.sv - single pixel request channel (req/gnt plus write payload)
interface framebuffer_arbiter_if
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH = FB_DATA_WIDTH
);

  logic                  req;
  logic                  gnt;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;

  modport master (output req, output we, output addr, output wdata, input gnt);
  modport slave  (input req, input we, input addr, input wdata, output gnt);

endinterface

// File: rtl/fb_clear_engine.sv
// rtl/fb_clear_engine.sv - fills every pixel address with one colour, one write per grant
module fb_clear_engine
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH = FB_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_color,
  output logic                  o_busy,
  framebuffer_arbiter_if.master bus
);

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] color_q, color_d;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_IDLE;
      addr_q  <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      color_q <= color_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    color_d = color_q;
    unique case (state_q)
      CLR_IDLE: begin
        if (i_start) begin
          state_d = CLR_FILL;
          addr_d  = '0;
          color_d = i_color;
        end
      end
      CLR_FILL: begin
        // Only advance when the arbiter actually let the write through.
        if (bus.gnt) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          if (&addr_q) state_d = CLR_DONE;
        end
      end
      CLR_DONE: state_d = CLR_IDLE;
      default:  state_d = CLR_IDLE;
    endcase
  end

  assign bus.req   = (state_q == CLR_FILL);
  assign bus.we    = 1'b1;
  assign bus.addr  = addr_q;
  assign bus.wdata = color_q;
  assign o_busy    = (state_q != CLR_IDLE);

endmodule

// File: rtl/framebuffer_arbiter.sv
// rtl/framebuffer_arbiter.sv - shares the pixel RAM between scan reads, host access and the clear engine
module framebuffer_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH   = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH   = FB_DATA_WIDTH,
  parameter int MAX_SCAN_RUN = 8
) (
  input  logic                  i_clk,
  input  logic                  rst_n,
  input  logic                  i_scan_req,
  input  logic [ADDR_WIDTH-1:0] i_scan_addr,
  output logic                  o_scan_gnt,
  output logic                  o_scan_rvalid,
  output logic [DATA_WIDTH-1:0] o_scan_rdata,
  input  logic                  i_host_valid,
  output logic                  o_host_ready,
  input  logic                  i_host_we,
  input  logic [ADDR_WIDTH-1:0] i_host_addr,
  input  logic [DATA_WIDTH-1:0] i_host_wdata,
  output logic                  o_host_rvalid,
  output logic [DATA_WIDTH-1:0] o_host_rdata,
  input  logic                  i_clear_start,
  input  logic [DATA_WIDTH-1:0] i_clear_color,
  output logic                  o_clear_busy,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_din,
  input  logic [DATA_WIDTH-1:0] i_ram_dout
);

  localparam logic [7:0] RUN_MAX = 8'(MAX_SCAN_RUN);

  framebuffer_arbiter_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) clr_if ();

  logic clr_busy;

  fb_clear_engine #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_clear (
    .i_clk   (i_clk),
    .rst_n   (rst_n),
    .i_start (i_clear_start),
    .i_color (i_clear_color),
    .o_busy  (clr_busy),
    .bus     (clr_if)
  );

  logic [7:0]            run_cnt_q, run_cnt_d;
  owner_e                owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic                  at_limit, sec_pending, sec_elig;
  logic                  scan_win, host_win, clr_win;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_q  <= '0;
      owner_q    <= OWN_NONE;
      ram_addr_q <= '0;
    end else begin
      run_cnt_q  <= run_cnt_d;
      owner_q    <= owner_d;
      ram_addr_q <= ram_addr_d;
    end
  end

  always_comb begin
    at_limit    = (run_cnt_q == RUN_MAX);
    sec_pending = clr_busy ? clr_if.req : i_host_valid;
    scan_win    = i_scan_req && !(at_limit && sec_pending);
    // Eligibility ignores host valid so ready never depends on valid through scan_win.
    sec_elig    = !i_scan_req || at_limit;
    host_win    = sec_elig && !clr_busy && i_host_valid;
    clr_win     = sec_elig && clr_busy && clr_if.req;

    run_cnt_d = run_cnt_q;
    if (!sec_pending || host_win || clr_win) begin
      run_cnt_d = '0;
    end else if (scan_win && !at_limit) begin
      run_cnt_d = run_cnt_q + 8'd1;
    end

    o_ram_we   = 1'b0;
    o_ram_din  = '0;
    o_ram_addr = ram_addr_q;
    owner_d    = OWN_NONE;
    if (scan_win) begin
      o_ram_addr = i_scan_addr;
      owner_d    = OWN_SCAN;
    end else if (host_win) begin
      o_ram_addr = i_host_addr;
      o_ram_we   = i_host_we;
      o_ram_din  = i_host_we ? i_host_wdata : '0;
      owner_d    = i_host_we ? OWN_NONE : OWN_HOST;
    end else if (clr_win) begin
      o_ram_addr = clr_if.addr;
      o_ram_we   = clr_if.we;
      o_ram_din  = clr_if.wdata;
    end
    ram_addr_d = o_ram_addr;

    clr_if.gnt   = clr_win;
    o_scan_gnt   = scan_win;
    o_host_ready = host_win;
  end

  assign o_scan_rvalid = (owner_q == OWN_SCAN);
  assign o_host_rvalid = (owner_q == OWN_HOST);
  assign o_scan_rdata  = o_scan_rvalid ? i_ram_dout : '0;
  assign o_host_rdata  = o_host_rvalid ? i_ram_dout : '0;
  assign o_clear_busy  = clr_busy;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// tb/tb_framebuffer_arbiter.sv - randomized scoreboard bench for framebuffer_arbiter
module tb_framebuffer_arbiter;
  import fb_pkg::*;

  localparam int AW = 11;
  localparam int DW = 24;
  localparam int MAXR = 8;
  localparam int DEPTH = 2048;
  localparam int W_NONE = 0, W_SCAN = 1, W_HOST = 2, W_CLR = 3;

  logic i_clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 i_clk = ~i_clk;

  logic          i_scan_req = 1'b0;
  logic [AW-1:0] i_scan_addr = '0;
  logic          o_scan_gnt, o_scan_rvalid;
  logic [DW-1:0] o_scan_rdata;
  logic          o_host_rvalid;
  logic [DW-1:0] o_host_rdata;
  logic          i_clear_start = 1'b0;
  logic [DW-1:0] i_clear_color = '0;
  logic          o_clear_busy;
  logic          o_ram_we;
  logic [AW-1:0] o_ram_addr;
  logic [DW-1:0] o_ram_din;
  logic [DW-1:0] i_ram_dout = '0;

  framebuffer_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) host_bus ();

  framebuffer_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_SCAN_RUN(MAXR)) dut (
    .i_clk(i_clk), .rst_n(rst_n),
    .i_scan_req(i_scan_req), .i_scan_addr(i_scan_addr), .o_scan_gnt(o_scan_gnt),
    .o_scan_rvalid(o_scan_rvalid), .o_scan_rdata(o_scan_rdata),
    .i_host_valid(host_bus.req), .o_host_ready(host_bus.gnt), .i_host_we(host_bus.we),
    .i_host_addr(host_bus.addr), .i_host_wdata(host_bus.wdata),
    .o_host_rvalid(o_host_rvalid), .o_host_rdata(o_host_rdata),
    .i_clear_start(i_clear_start), .i_clear_color(i_clear_color), .o_clear_busy(o_clear_busy),
    .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr), .o_ram_din(o_ram_din), .i_ram_dout(i_ram_dout)
  );

  function automatic logic [DW-1:0] pix_init(int i);
    return DW'(i * 40503 + 12345);
  endfunction

  // Pixel RAM: synchronous, one cycle read latency.
  logic [DW-1:0] ram [DEPTH];
  bit preloaded = 1'b0;
  always @(posedge i_clk) begin
    if (!preloaded) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= pix_init(i);
      preloaded <= 1'b1;
    end else if (o_ram_we) begin
      ram[o_ram_addr] <= o_ram_din;
    end
    i_ram_dout <= ram[o_ram_addr];
  end

  int checks = 0;
  int failures = 0;
  int cycle_cnt = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cycle_cnt);
    end
  endtask

  always @(posedge i_clk) cycle_cnt <= cycle_cnt + 1;

  // Reference model state
  typedef struct {
    owner_e        who;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t          exp_q[$];
  logic [DW-1:0] model_mem [DEPTH];
  int            m_phase = 0;
  int            m_ptr = 0;
  int            m_streak = 0;
  logic [DW-1:0] m_color = '0;
  logic [AW-1:0] m_last_addr = '0;
  bit            host_fired = 1'b0;
  int            busy_cycles = 0;
  bit            count_en = 1'b0;
  int            host_cnt = 0;
  int            scan_cnt = 0;

  always @(negedge i_clk) begin
    bit            busy, sec, e_we;
    int            win;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    if (rst_n) begin
      busy = (m_phase != 0);
      sec  = (m_phase == 1) || (m_phase == 0 && host_bus.req);
      win  = W_NONE;
      if (i_scan_req && !(m_streak >= MAXR && sec)) win = W_SCAN;
      else if (m_phase == 1) win = W_CLR;
      else if (m_phase == 0 && host_bus.req) win = W_HOST;

      e_we = 1'b0;
      e_addr = m_last_addr;
      e_din = '0;
      if (win == W_SCAN) e_addr = i_scan_addr;
      if (win == W_HOST) begin
        e_addr = host_bus.addr;
        e_we   = host_bus.we;
        e_din  = host_bus.we ? host_bus.wdata : '0;
      end
      if (win == W_CLR) begin
        e_addr = AW'(m_ptr);
        e_we   = 1'b1;
        e_din  = m_color;
      end

      chk("scan_gnt", o_scan_gnt, win == W_SCAN);
      chk("host_ready", host_bus.gnt, win == W_HOST);
      chk("clear_busy", o_clear_busy, busy);
      chk("ram_we", o_ram_we, e_we);
      chk("ram_addr", o_ram_addr, e_addr);
      chk("ram_din", o_ram_din, e_din);

      m_last_addr = e_addr;
      if (win == W_SCAN) exp_q.push_back('{OWN_SCAN, model_mem[i_scan_addr], cycle_cnt});
      if (win == W_HOST) begin
        host_fired = 1'b1;
        if (host_bus.we) model_mem[host_bus.addr] = host_bus.wdata;
        else exp_q.push_back('{OWN_HOST, model_mem[host_bus.addr], cycle_cnt});
      end
      if (!sec || win == W_HOST || win == W_CLR) m_streak = 0;
      else if (win == W_SCAN && m_streak < MAXR) m_streak++;

      if (m_phase == 2) begin
        m_phase = 0;
      end else if (m_phase == 1) begin
        if (win == W_CLR) begin
          model_mem[m_ptr] = m_color;
          m_ptr++;
          if (m_ptr == DEPTH) m_phase = 2;
        end
      end else if (i_clear_start) begin
        m_phase = 1;
        m_ptr   = 0;
        m_color = i_clear_color;
      end
      if (o_clear_busy) busy_cycles++;
    end
  end

  // Monitor: pops one expectation per read-data pulse.
  always @(negedge i_clk) begin
    exp_t e;
    if (rst_n) begin
      if (o_scan_rvalid || o_host_rvalid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rvalid", {o_scan_rvalid, o_host_rvalid}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          chk("rvalid_owner", {o_scan_rvalid, o_host_rvalid}, (e.who == OWN_SCAN) ? 2'b10 : 2'b01);
          chk("rvalid_latency", cycle_cnt, e.cyc + 1);
          chk("rdata", (e.who == OWN_SCAN) ? o_scan_rdata : o_host_rdata, e.data);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc + 1 == cycle_cnt) begin
        chk("missing_rvalid", 1'b0, 1'b1);
        void'(exp_q.pop_front());
      end
    end
  end

  always @(negedge i_clk) begin
    if (count_en) begin
      host_cnt += int'(host_bus.gnt);
      scan_cnt += int'(o_scan_gnt);
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(int p_scan, int p_host, int p_clr, bit narrow);
    i_scan_req  = ($urandom_range(0, 99) < p_scan);
    i_scan_addr = narrow ? AW'($urandom_range(0, 31)) : AW'($urandom);
    if (!host_bus.req || host_fired) begin
      host_fired     = 1'b0;
      host_bus.req   = ($urandom_range(0, 99) < p_host);
      host_bus.we    = 1'($urandom_range(0, 1));
      host_bus.addr  = narrow ? AW'($urandom_range(0, 31)) : AW'($urandom);
      host_bus.wdata = DW'($urandom);
    end
    i_clear_start = ($urandom_range(0, 999) < p_clr);
    i_clear_color = DW'($urandom);
    tick();
  endtask

  task automatic enter_reset();
    rst_n = 1'b0;
    i_scan_req = 1'b0;
    host_bus.req = 1'b0;
    i_clear_start = 1'b0;
    exp_q.delete();
    m_phase = 0;
    m_streak = 0;
    m_last_addr = '0;
    host_fired = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("reset_outputs_a", {o_scan_gnt, o_scan_rvalid, o_scan_rdata, o_host_rvalid, o_host_rdata}, '0);
    chk("reset_outputs_b", {host_bus.gnt, o_clear_busy, o_ram_we, o_ram_addr, o_ram_din}, '0);
  endtask

  task automatic wait_clear_done(int bound, int p_scan);
    int n = 0;
    while (o_clear_busy && n < bound) begin
      drive(p_scan, 0, 0, 1'b0);
      n++;
    end
    chk("clear_timeout", o_clear_busy, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = pix_init(i);
    host_bus.req = 1'b0; host_bus.we = 1'b0; host_bus.addr = '0; host_bus.wdata = '0;
    #2;
    enter_reset();
    repeat (3) tick();
    check_reset_outputs();
    rst_n = 1'b1;
    tick();

    // Host write then read, scan idle
    host_bus.req = 1'b1; host_bus.we = 1'b1; host_bus.addr = 11'h155; host_bus.wdata = 24'h12AB34;
    tick();
    host_bus.we = 1'b0;
    tick();
    host_bus.req = 1'b0;
    host_fired = 1'b0;
    @(negedge i_clk);
    chk("host_rd_valid", o_host_rvalid, 1'b1);
    chk("host_rd_data", o_host_rdata, 24'h12AB34);
    repeat (3) tick();

    // Scan only
    for (int a = 0; a < 3; a++) begin
      i_scan_req = 1'b1;
      i_scan_addr = AW'(a);
      tick();
    end
    repeat (20) drive(100, 0, 0, 1'b0);
    i_scan_req = 1'b0;
    repeat (2) tick();

    // Starvation guard: 8 scans, then one host transfer
    count_en = 1'b1;
    repeat (90) drive(100, 100, 0, 1'b1);
    count_en = 1'b0;
    chk("starve_host_grants", host_cnt, 10);
    chk("starve_scan_grants", scan_cnt, 80);
    repeat (200) drive(100, 100, 0, 1'b1);
    i_scan_req = 1'b0; host_bus.req = 1'b0; host_fired = 1'b0;
    repeat (3) tick();

    // Clear, no scan traffic, host read request held throughout
    busy_cycles = 0;
    host_bus.req = 1'b1; host_bus.we = 1'b0; host_bus.addr = 11'h010;
    i_clear_start = 1'b1; i_clear_color = 24'h0000FF;
    tick();
    i_clear_start = 1'b0;
    for (int n = 0; n < 2200 && o_clear_busy; n++) tick();
    chk("clear_timeout", o_clear_busy, 1'b0);
    chk("clear_busy_cycles", busy_cycles, 2049);
    host_bus.req = 1'b0; host_fired = 1'b0;
    tick();
    for (int a = 0; a < DEPTH; a++) begin
      i_scan_req = 1'b1;
      i_scan_addr = AW'(a);
      tick();
    end
    i_scan_req = 1'b0;
    repeat (2) tick();

    // Clear under continuous scan load
    busy_cycles = 0;
    i_clear_start = 1'b1; i_clear_color = 24'hA5C30F; i_scan_req = 1'b1;
    tick();
    wait_clear_done(19000, 100);
    chk("clear_load_busy_cycles", busy_cycles, 18433);
    i_scan_req = 1'b0;
    repeat (2) tick();

    // Mixed random traffic
    repeat (2500) drive(60, 50, 1, 1'b1);
    wait_clear_done(20000, 60);
    i_scan_req = 1'b0; host_bus.req = 1'b0; host_fired = 1'b0;
    repeat (3) tick();

    // Reset in the middle of a clear
    drive(50, 0, 1000, 1'b0);
    for (int n = 0; n < 2000 && !(m_phase == 1 && m_ptr == 100); n++) drive(50, 0, 0, 1'b0);
    chk("midclear_busy", o_clear_busy, 1'b1);
    enter_reset();
    #1;
    check_reset_outputs();
    tick();
    check_reset_outputs();
    rst_n = 1'b1;
    tick();
    chk("busy_after_reset", o_clear_busy, 1'b0);
    i_clear_start = 1'b1; i_clear_color = 24'h00FF00;
    tick();
    i_clear_start = 1'b0;
    chk("restart_addr0", {o_ram_we, o_ram_addr}, {1'b1, 11'h000});
    wait_clear_done(2200, 0);

    repeat (5) drive(0, 0, 0, 1'b0);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/framebuffer_arbiter.md
Name: framebuffer_arbiter

Overview:
- Shares the single-port synchronous pixel RAM (ADDR_WIDTH=11, DATA_WIDTH=24, 1-cycle read latency) between two requesters.
- The first requester is the LED matrix scan engine, which only reads. The second is a host-side port that reads and writes.
- A built-in clear engine fills the whole framebuffer with one colour.
- Sits between led_matrix_controller, the host interface and the pixel RAM instance in the top level.

Parameters:
- ADDR_WIDTH, 11, pixel RAM address width (2048 pixels = 64x32).
- DATA_WIDTH, 24, pixel width (8-bit R,G,B).
- MAX_SCAN_RUN, 8, maximum consecutive scan grants while a host/clear request is pending; range 1..255.

Ports:
- i_clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_scan_req  in  1  scan read request
- i_scan_addr  in  ADDR_WIDTH  scan read address
- o_scan_gnt  out  1  scan request accepted this cycle
- o_scan_rvalid  out  1  o_scan_rdata valid
- o_scan_rdata  out  DATA_WIDTH  scan read data
- i_host_valid  in  1  host request valid
- o_host_ready  out  1  host request accepted this cycle
- i_host_we  in  1  1 = write, 0 = read
- i_host_addr  in  ADDR_WIDTH  host address
- i_host_wdata  in  DATA_WIDTH  host write data
- o_host_rvalid  out  1  host read data valid
- o_host_rdata  out  DATA_WIDTH  host read data
- i_clear_start  in  1  pulse: begin fill
- i_clear_color  in  DATA_WIDTH  fill colour (sampled on start)
- o_clear_busy  out  1  fill in progress
- o_ram_we  out  1  RAM write enable
- o_ram_addr  out  ADDR_WIDTH  RAM address
- o_ram_din  out  DATA_WIDTH  RAM write data
- i_ram_dout  in  DATA_WIDTH  RAM read data

Behaviour:
- Reset (async assert, sync release) forces:
  - all outputs to 0;
  - the clear FSM to IDLE;
  - the run counter to 0;
  - the read-owner tag to NONE.
- Arbitration is evaluated every cycle. Grant order:
  - Scan is granted if i_scan_req is set, unless run_cnt == MAX_SCAN_RUN and a secondary request is pending.
  - Otherwise the secondary requester is granted. The secondary is the clear engine when busy; otherwise the host.
- Host is blocked during a clear: o_host_ready = 0 while o_clear_busy = 1.
- run_cnt rules:
  - Increments on a scan grant while a secondary request is pending.
  - Clears on any secondary grant or when no secondary request is pending.
  - Saturates at MAX_SCAN_RUN.
- RAM port signals are combinational from the granted request.
  - Host write: o_ram_we = 1, o_ram_din = i_host_wdata.
  - Idle cycle: o_ram_we = 0, o_ram_addr holds its last value.
- Read latency:
  - A read granted in cycle T is registered with an owner tag (SCAN or HOST).
  - In T+1 the tagged rvalid pulses for 1 cycle, with rdata = i_ram_dout.
  - Back-to-back grants give one rvalid per cycle.
  - A host write produces no rvalid.
- Handshakes:
  - o_host_ready is combinational (valid-independent grant eligibility AND i_host_valid). A transfer occurs when valid && ready.
  - o_scan_gnt = i_scan_req && scan won.
- Clear FSM states are IDLE, FILL and DONE.
  - IDLE -> FILL on i_clear_start. This latches the colour, sets the address to 0 and sets o_clear_busy = 1.
  - In FILL, each secondary grant writes the colour to the current address, then increments it.
  - FILL -> DONE after writing address 2^ADDR_WIDTH-1.
  - DONE -> IDLE next cycle, with busy deasserting in IDLE.
  - i_clear_start while busy is ignored.
- Simultaneous events:
  - i_clear_start in the same cycle as a host transfer: the host transfer completes first; the clear's first write occurs no earlier than the next cycle.
  - Scan and clear both pending with run_cnt < MAX: scan wins.
- Reset mid-clear aborts the fill. RAM contents are left partially written.

Decomposition:
- Package fb_pkg holds:
  - the owner-tag enum (NONE/SCAN/HOST);
  - the clear FSM state enum;
  - default ADDR_WIDTH/DATA_WIDTH localparams shared with led_matrix_controller.
- Sub-module fb_clear_engine: clear FSM plus address counter. It exposes a req/gnt pair to the arbiter core.

Test Plan:
- Scan only: i_scan_req held, addrs 0,1,2 with RAM preloaded. Expect gnt every cycle, and o_scan_rvalid in T+1 with rdata = mem[0], mem[1], mem[2]. No host rvalid.
- Host write then read, scan idle: write 0x12AB34 to addr 0x155, then read 0x155. Expect ready in both cycles, o_ram_we = 1 only in the first, and o_host_rvalid one cycle after the read with rdata = 0x12AB34.
- Starvation guard: scan requests continuously, host valid from cycle 0, MAX_SCAN_RUN = 8. Expect 8 scan grants, then 1 host ready, pattern repeating. rvalid tags must match the owner each cycle.
- Clear: i_clear_start with colour 0x0000FF and no scan traffic. Expect busy for 2048 write cycles plus DONE, with every addr 0..2047 reading 0x0000FF. Host ready = 0 throughout.
- Clear under scan load, MAX_SCAN_RUN = 8: expect exactly 1 clear write per 9 cycles and completion after 2048 clear writes. Scan rdata stays correct throughout.
- Reset mid-clear: deassert rst_n at clear address 100. Expect all outputs to go to 0 immediately and busy = 0 after release. A new clear_start restarts from address 0.
